// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential nibble multiplier controller.
package mult_seq_pkg;

    localparam int NIB_W = 4;
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {IDLE, MUL, DONE} mult_seq_state_t;

    // Nibble idx of a zero-extended operand; idx covers up to 8 nibbles.
    function automatic logic [NIB_W-1:0] nib_sel(input logic [MAX_W-1:0] v, input logic [2:0] idx);
        return v[{idx, 2'b00} +: NIB_W];
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_nib_mul.sv
// Combinational 4x4 -> 8 unsigned multiplier shared by every partial-product cycle.
module nib_mul
    import mult_seq_pkg::*;
(
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    output logic [2*NIB_W-1:0] p
);

    assign p = {{NIB_W{1'b0}}, a} * {{NIB_W{1'b0}}, b};

endmodule

// File: rtl/mult_seq_ctrl.sv
// Iterative WIDTH x WIDTH unsigned multiplier sequencing nibble pairs through one nib_mul.
// Optional MULT_SEQ_ZERO_SKIP_EN: a zero operand finishes after a single MUL cycle.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);

    localparam int N     = WIDTH / NIB_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 2 * WIDTH;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    mult_seq_state_t state, nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IDX_W-1:0] i_q, j_q;
    logic [ACC_W-1:0] acc_q;
    logic             accept, step, last;
    logic [NIB_W-1:0] a_nib, b_nib;
    logic [2*NIB_W-1:0] pp;
    logic [5:0]       shamt;

    assign a_nib = nib_sel(MAX_W'(a_q), 3'(i_q));
    assign b_nib = nib_sel(MAX_W'(b_q), 3'(j_q));
    assign shamt = 6'((32'(i_q) + 32'(j_q)) * NIB_W);
    assign last  = (i_q == LAST) && (j_q == LAST);

    nib_mul u_nib_mul (
        .a (a_nib),
        .b (b_nib),
        .p (pp)
    );

`ifdef MULT_SEQ_ZERO_SKIP_EN
    logic zero_op;
    assign zero_op = (a_q == '0) || (b_q == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        nxt    = state;
        accept = 1'b0;
        step   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    nxt    = MUL;
                end
            end
            MUL: begin
`ifdef MULT_SEQ_ZERO_SKIP_EN
                // acc was cleared on accept, so a zero operand can leave immediately.
                if (zero_op) nxt = DONE;
                else
`endif
                begin
                    step = 1'b1;
                    if (last) nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            acc_q <= '0;
        end else if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            i_q   <= '0;
            j_q   <= '0;
            acc_q <= '0;
        end else if (step) begin
            acc_q <= acc_q + (ACC_W'(pp) << shamt);
            if (j_q == LAST) begin
                j_q <= '0;
                i_q <= i_q + 1'b1;
            end else begin
                j_q <= j_q + 1'b1;
            end
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign out_product = acc_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl at WIDTH=8 and WIDTH=12 against a plain a*b reference.
module tb_mult_seq_ctrl;

`ifdef MULT_SEQ_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, busy8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;

    logic        iv12 = 1'b0, ir12, ov12, or12 = 1'b0, busy12;
    logic [11:0] a12 = '0, b12 = '0;
    logic [23:0] p12;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .out_valid(ov8), .out_ready(or8), .out_product(p8), .busy(busy8)
    );

    mult_seq_ctrl #(.WIDTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv12), .in_ready(ir12), .in_a(a12), .in_b(b12),
        .out_valid(ov12), .out_ready(or12), .out_product(p12), .busy(busy12)
    );

    function automatic logic [3:0] flags(input bit w12);
        return w12 ? {ir12, ov12, busy12, 1'b0} : {ir8, ov8, busy8, 1'b0};
    endfunction

    function automatic logic [23:0] prod(input bit w12);
        return w12 ? p12 : {8'h00, p8};
    endfunction

    // Called and returns at a negedge. keep_valid leaves in_valid high with 0x0F/0x0F after accept.
    task automatic do_op(input string name, input bit w12, input logic [11:0] a, input logic [11:0] b,
                         input int hold, input bit keep_valid);
        logic [23:0] exp_p;
        int          exp_lat, cyc;
        bit          rdy_bad;
        exp_p   = 24'(a) * 24'(b);
        exp_lat = (ZS && (a == 0 || b == 0)) ? 1 : (w12 ? 9 : 4);

        n_cmp++;
        if (flags(w12) !== 4'b1000) begin
            n_bad++;
            $display("FAIL %s idle_flags got=%b want=1000", name, flags(w12));
        end
        if (w12) begin iv12 = 1'b1; a12 = a; b12 = b; end
        else     begin iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; end
        @(posedge clk);
        @(negedge clk);
        if (keep_valid) begin
            if (w12) begin a12 = 12'h00F; b12 = 12'h00F; end
            else     begin a8 = 8'h0F; b8 = 8'h0F; end
        end else begin
            iv8 = 1'b0; iv12 = 1'b0;
            if (w12) begin a12 = 12'($urandom); b12 = 12'($urandom); end
            else     begin a8 = 8'($urandom); b8 = 8'($urandom); end
        end

        cyc = 0;
        rdy_bad = 1'b0;
        while (!flags(w12)[2] && cyc < 200) begin
            if (flags(w12)[3] !== 1'b0 || flags(w12)[1] !== 1'b1) rdy_bad = 1'b1;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (cyc !== exp_lat) begin
            n_bad++;
            $display("FAIL %s latency got=%0d want=%0d", name, cyc, exp_lat);
        end
        n_cmp++;
        if (rdy_bad) begin
            n_bad++;
            $display("FAIL %s in_ready/busy during MUL got=bad want=ready0_busy1", name);
        end

        for (int h = 0; h < hold; h++) begin
            n_cmp++;
            if (flags(w12) !== 4'b0110 || prod(w12) !== exp_p) begin
                n_bad++;
                $display("FAIL %s hold%0d flags=%b prod=%h want flags=0110 prod=%h",
                         name, h, flags(w12), prod(w12), exp_p);
            end
            @(posedge clk);
            @(negedge clk);
        end

        if (w12) or12 = 1'b1; else or8 = 1'b1;
        n_cmp++;
        if (flags(w12) !== 4'b0110 || prod(w12) !== exp_p) begin
            n_bad++;
            $display("FAIL %s handoff flags=%b prod=%h want flags=0110 prod=%h",
                     name, flags(w12), prod(w12), exp_p);
        end
        @(posedge clk);
        @(negedge clk);
        or8 = 1'b0; or12 = 1'b0;
        n_cmp++;
        if (flags(w12) !== 4'b1000) begin
            n_bad++;
            $display("FAIL %s after_handoff flags=%b want=1000", name, flags(w12));
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({ir8, ov8, busy8, p8} !== {3'b100, 16'h0000} || {ir12, ov12, busy12, p12} !== {3'b100, 24'h0}) begin
            n_bad++;
            $display("FAIL reset_state got8=%b/%h got12=%b/%h want=100/0", {ir8, ov8, busy8}, p8,
                     {ir12, ov12, busy12}, p12);
        end
    endtask

    task automatic test_basic();
        do_op("basic_12x34", 1'b0, 12'h012, 12'h034, 0, 1'b0);
        do_op("ff_x_ff_hold3", 1'b0, 12'h0FF, 12'h0FF, 3, 1'b0);
    endtask

    task automatic test_ignore_inputs();
        do_op("ignore_first", 1'b0, 12'h012, 12'h034, 1, 1'b1);
        do_op("ignore_second", 1'b0, 12'h00F, 12'h00F, 0, 1'b0);
    endtask

    task automatic test_mid_reset();
        bit seen;
        iv8 = 1'b1; a8 = 8'hAB; b8 = 8'hCD;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ir8, ov8, busy8, p8} !== {3'b100, 16'h0000}) begin
            n_bad++;
            $display("FAIL mid_reset got=%b/%h want=100/0000", {ir8, ov8, busy8}, p8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ov8 !== 1'b0 || busy8 !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL mid_reset_no_result got=activity want=idle");
        end
    endtask

    task automatic test_width12();
        do_op("w12_fff_x_fff", 1'b1, 12'hFFF, 12'hFFF, 0, 1'b0);
        do_op("w12_abc_x_123", 1'b1, 12'hABC, 12'h123, 1, 1'b0);
    endtask

    task automatic test_zero();
        do_op("zero_00_x_5a", 1'b0, 12'h000, 12'h05A, 0, 1'b0);
        do_op("zero_5a_x_00", 1'b0, 12'h05A, 12'h000, 1, 1'b0);
        do_op("w12_zero", 1'b1, 12'h000, 12'h777, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [11:0] a, b;
        for (int k = 0; k < 12; k++) begin
            a = 12'($urandom_range(0, 255));
            b = 12'($urandom_range(0, 255));
            if (k % 5 == 4) a = '0;
            do_op($sformatf("rand8_%0d", k), 1'b0, a, b, $urandom_range(0, 2), 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            a = 12'($urandom);
            b = 12'($urandom);
            do_op($sformatf("rand12_%0d", k), 1'b1, a, b, $urandom_range(0, 2), 1'b0);
        end
    endtask

    initial begin
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_ignore_inputs();
        test_mid_reset();
        test_width12();
        test_zero();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
